// File: rtl/digi_ota_array.sv
`default_nettype none
// ============================================================================
// Module      : digi_ota_array
// Description : Clocked multi-channel digital OTA. For each channel, the
//               vip/vin pair is synchronised, classified as UP/DN/CM,
//               deglitched by a persistence counter, and committed to a
//               registered tri-state style output (out/out_oe). A saturating
//               up/down integrator emulates charge delivered to a load.
// Ports       : clk, rst (async, active-high), ena (global enable),
//               mode (0 = release on CM, 1 = hold last drive),
//               deglitch_len (extra samples a new condition must persist),
//               acc_clr (sync clear of integrators to midscale),
//               vip/vin [CHANNELS] async inputs,
//               out/out_oe/changed [CHANNELS],
//               acc [CHANNELS*ACC_W] (channel i at [i*ACC_W +: ACC_W]).
// Revision    : 1.0 - initial release
// ============================================================================
module digi_ota_array #(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int DEGLITCH_W  = 4,
  parameter int ACC_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      mode,
  input  logic [DEGLITCH_W-1:0]     deglitch_len,
  input  logic                      acc_clr,
  input  logic [CHANNELS-1:0]       vip,
  input  logic [CHANNELS-1:0]       vin,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       out_oe,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS*ACC_W-1:0] acc
);

  typedef enum logic [1:0] {
    COND_CM = 2'd0,
    COND_UP = 2'd1,
    COND_DN = 2'd2
  } cond_t;

  localparam logic [ACC_W-1:0]      ACC_MID = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]      ACC_MAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0]      ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [DEGLITCH_W:0]   CNT_ONE = {{DEGLITCH_W{1'b0}}, 1'b1};

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sp_q, sp_d, sn_q, sn_d;
    cond_t                  c_q, c_d, p_q, p_d, smp;
    logic [DEGLITCH_W-1:0]  cnt_q, cnt_d;
    logic [DEGLITCH_W:0]    cnt_inc;
    logic                   out_q, out_d, oe_q, oe_d, chg_q, chg_d;
    logic                   seen_q, seen_d;
    logic [ACC_W-1:0]       acc_q, acc_d;

    always_comb begin
      sp_d    = {sp_q[SYNC_STAGES-2:0], vip[gi]};
      sn_d    = {sn_q[SYNC_STAGES-2:0], vin[gi]};

      case ({sp_q[SYNC_STAGES-1], sn_q[SYNC_STAGES-1]})
        2'b10:   smp = COND_UP;
        2'b01:   smp = COND_DN;
        default: smp = COND_CM;
      endcase

      // Pending candidate equal to the committed condition means "nothing
      // pending"; this keeps the candidate compare a plain equality.
      c_d     = c_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      cnt_inc = {1'b0, cnt_q} + CNT_ONE;
      if (!ena) begin
        c_d   = COND_CM;
        p_d   = COND_CM;
        cnt_d = '0;
      end else if (smp == c_q) begin
        p_d   = c_q;
        cnt_d = '0;
      end else if (smp != p_q) begin
        p_d   = smp;
        cnt_d = '0;
        if (deglitch_len == '0) begin
          c_d = smp;
        end
      end else begin
        // >= so that shrinking deglitch_len mid-count commits promptly
        if (cnt_inc >= {1'b0, deglitch_len}) begin
          c_d   = p_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc[DEGLITCH_W-1:0];
        end
      end

      chg_d  = (c_d != c_q);
      seen_d = seen_q;
      out_d  = out_q;
      oe_d   = oe_q;
      if (!ena) begin
        seen_d = 1'b0;
        out_d  = 1'b0;
        oe_d   = 1'b0;
      end else begin
        case (c_d)
          COND_UP: begin
            out_d  = 1'b1;
            oe_d   = 1'b1;
            seen_d = 1'b1;
          end
          COND_DN: begin
            out_d  = 1'b0;
            oe_d   = 1'b1;
            seen_d = 1'b1;
          end
          default: begin
            // Hold mode keeps driving the last decision, but only once a
            // decision has been made since enable/reset.
            if (mode) begin
              oe_d = seen_q;
            end else begin
              out_d = 1'b0;
              oe_d  = 1'b0;
            end
          end
        endcase
      end

      // Integrator follows the registered condition, one edge behind commit.
      acc_d = acc_q;
      if (acc_clr) begin
        acc_d = ACC_MID;
      end else if (ena) begin
        if (c_q == COND_UP && acc_q != ACC_MAX) begin
          acc_d = acc_q + ACC_ONE;
        end else if (c_q == COND_DN && acc_q != '0) begin
          acc_d = acc_q - ACC_ONE;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sp_q   <= '0;
        sn_q   <= '0;
        c_q    <= COND_CM;
        p_q    <= COND_CM;
        cnt_q  <= '0;
        out_q  <= 1'b0;
        oe_q   <= 1'b0;
        chg_q  <= 1'b0;
        seen_q <= 1'b0;
        acc_q  <= ACC_MID;
      end else begin
        sp_q   <= sp_d;
        sn_q   <= sn_d;
        c_q    <= c_d;
        p_q    <= p_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        oe_q   <= oe_d;
        chg_q  <= chg_d;
        seen_q <= seen_d;
        acc_q  <= acc_d;
      end
    end

    assign out[gi]                  = out_q;
    assign out_oe[gi]               = oe_q;
    assign changed[gi]              = chg_q;
    assign acc[gi*ACC_W +: ACC_W]   = acc_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_digi_ota_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_digi_ota_array
// Description : Scoreboard bench for digi_ota_array. Stimulus schedules
//               expected values against absolute clock-edge numbers; a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digi_ota_array;
  localparam int CH = 2;
  localparam int DW = 4;
  localparam int AW = 8;

  localparam int K_OUT = 0, K_OE = 1, K_CHG = 2, K_ACC0 = 3, K_ACC1 = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic           mode;
  logic [DW-1:0]  deglitch_len;
  logic           acc_clr;
  logic [CH-1:0]  vip, vin;
  logic [CH-1:0]  out, out_oe, changed;
  logic [CH*AW-1:0] acc;

  digi_ota_array #(
    .CHANNELS(CH), .SYNC_STAGES(2), .DEGLITCH_W(DW), .ACC_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .deglitch_len(deglitch_len), .acc_clr(acc_clr),
    .vip(vip), .vin(vin),
    .out(out), .out_oe(out_oe), .changed(changed), .acc(acc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic exp_at(input int c, input int k, input logic [31:0] v, input string nm);
    exp_t e;
    int   idx;
    e.cyc = c; e.kind = k; e.val = v; e.nm = nm;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_OUT:   return {30'd0, out};
      K_OE:    return {30'd0, out_oe};
      K_CHG:   return {30'd0, changed};
      K_ACC0:  return {24'd0, acc[7:0]};
      default: return {24'd0, acc[15:8]};
    endcase
  endfunction

  // Monitor: compares every scheduled expectation on the falling edge
  // following the rising edge it belongs to.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check for edge %0d not reached in time (now %0d)", e.nm, e.cyc, cyc);
      end else begin
        a = actual(e.kind);
        if (a !== e.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %0h, expected %0h", e.nm, cyc, a, e.val);
        end
      end
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t, t2;
  initial begin
    rst = 1'b1; ena = 1'b0; mode = 1'b0; deglitch_len = '0; acc_clr = 1'b0;
    vip = '0; vin = '0;
    go(3);
    rst = 1'b0;
    t = cyc;
    exp_at(t, K_OUT, 0, "rst_out");
    exp_at(t, K_OE, 0, "rst_oe");
    exp_at(t, K_CHG, 0, "rst_chg");
    exp_at(t, K_ACC0, 128, "rst_acc0");
    exp_at(t, K_ACC1, 128, "rst_acc1");

    // Basic latency, deglitch_len = 0
    go(1); t = cyc;
    ena = 1'b1; vip[0] = 1'b1;
    exp_at(t+2, K_OE, 0, "lat_oe_early");
    exp_at(t+2, K_CHG, 0, "lat_chg_early");
    exp_at(t+3, K_OUT, 2'b01, "lat_out");
    exp_at(t+3, K_OE, 2'b01, "lat_oe");
    exp_at(t+3, K_CHG, 2'b01, "lat_chg");
    exp_at(t+3, K_ACC0, 128, "acc_before_inc");
    exp_at(t+4, K_CHG, 0, "chg_pulse_end");
    exp_at(t+4, K_ACC0, 129, "acc_inc1");
    exp_at(t+5, K_ACC0, 130, "acc_inc2");
    exp_at(t+140, K_ACC0, 255, "acc_sat_hi");
    exp_at(t+140, K_ACC1, 128, "acc1_idle");
    go(145);

    // acc_clr beats the increment on the same edge
    t = cyc; acc_clr = 1'b1;
    exp_at(t+1, K_ACC0, 128, "accclr_acc0");
    exp_at(t+1, K_ACC1, 128, "accclr_acc1");
    go(1);
    acc_clr = 1'b0;
    t2 = cyc; vip[0] = 1'b0; vin[0] = 1'b1;
    exp_at(t2+1, K_ACC0, 129, "acc_after_clr");
    exp_at(t2+3, K_OUT, 0, "dn_out");
    exp_at(t2+3, K_OE, 2'b01, "dn_oe");
    exp_at(t2+3, K_CHG, 2'b01, "dn_chg");
    exp_at(t2+3, K_ACC0, 131, "dn_acc_last_up");
    exp_at(t2+4, K_ACC0, 130, "dn_acc_dec");
    exp_at(t2+300, K_ACC0, 0, "acc_sat_lo");
    exp_at(t2+300, K_ACC1, 128, "acc1_still_idle");
    go(302);

    // Deglitch: 3-cycle glitch must not commit with deglitch_len = 3
    t = cyc; deglitch_len = 4'd3; vip[1] = 1'b1;
    exp_at(t+6, K_CHG, 0, "glitch3_chg");
    exp_at(t+6, K_OE, 2'b01, "glitch3_oe");
    exp_at(t+8, K_OUT, 0, "glitch3_out");
    go(3); vip[1] = 1'b0;
    go(5);

    // 4-cycle pulse commits, then returns to CM after 4 CM samples
    t = cyc; vip[1] = 1'b1;
    exp_at(t+5, K_OE, 2'b01, "pulse4_oe_early");
    exp_at(t+6, K_OUT, 2'b10, "pulse4_out");
    exp_at(t+6, K_OE, 2'b11, "pulse4_oe");
    exp_at(t+6, K_CHG, 2'b10, "pulse4_chg");
    exp_at(t+7, K_CHG, 0, "pulse4_chg_end");
    exp_at(t+9, K_OE, 2'b11, "pulse4_cm_early");
    exp_at(t+10, K_OE, 2'b01, "pulse4_cm_oe");
    exp_at(t+10, K_OUT, 0, "pulse4_cm_out");
    exp_at(t+10, K_CHG, 2'b10, "pulse4_cm_chg");
    exp_at(t+12, K_ACC1, 132, "pulse4_acc1");
    go(4); vip[1] = 1'b0;
    go(8);

    // UP,UP,DN,UP,UP,UP: the DN sample restarts the count, no commit
    t = cyc; vip[1] = 1'b1;
    exp_at(t+8, K_OE, 2'b01, "interleave_oe8");
    exp_at(t+9, K_OE, 2'b01, "interleave_oe9");
    exp_at(t+9, K_CHG, 0, "interleave_chg");
    exp_at(t+11, K_OUT, 0, "interleave_out");
    go(2); vip[1] = 1'b0; vin[1] = 1'b1;
    go(1); vip[1] = 1'b1; vin[1] = 1'b0;
    go(3); vip[1] = 1'b0;
    go(5);

    // Mode contrast
    t = cyc; deglitch_len = '0; mode = 1'b0; vip[1] = 1'b1;
    exp_at(t+3, K_OUT, 2'b10, "m0_up_out");
    exp_at(t+3, K_OE, 2'b11, "m0_up_oe");
    go(5);
    t = cyc; vin[1] = 1'b1;
    exp_at(t+3, K_OUT, 0, "m0_cm_out");
    exp_at(t+3, K_OE, 2'b01, "m0_cm_oe");
    exp_at(t+3, K_CHG, 2'b10, "m0_cm_chg");
    go(5);
    t = cyc; mode = 1'b1; vin[1] = 1'b0;
    exp_at(t+3, K_OUT, 2'b10, "m1_up_out");
    exp_at(t+3, K_OE, 2'b11, "m1_up_oe");
    go(5);
    t = cyc; vin[1] = 1'b1;
    exp_at(t+3, K_OUT, 2'b10, "m1_cm_out");
    exp_at(t+3, K_OE, 2'b11, "m1_cm_oe");
    exp_at(t+3, K_CHG, 2'b10, "m1_cm_chg");
    exp_at(t+4, K_OE, 2'b11, "m1_cm_hold");
    exp_at(t+4, K_CHG, 0, "m1_cm_chg_end");
    go(5);
    t = cyc; mode = 1'b0;
    exp_at(t+1, K_OE, 2'b01, "m1to0_oe");
    exp_at(t+1, K_OUT, 0, "m1to0_out");
    exp_at(t+1, K_CHG, 0, "m1to0_chg");
    go(3);

    // ena drop while channels drive
    t = cyc; vin[1] = 1'b0;
    exp_at(t+3, K_OUT, 2'b10, "pre_ena_out");
    exp_at(t+3, K_OE, 2'b11, "pre_ena_oe");
    go(6);
    t = cyc; ena = 1'b0; mode = 1'b1; vip = '0; vin = '0;
    exp_at(t+1, K_OUT, 0, "ena0_out");
    exp_at(t+1, K_OE, 0, "ena0_oe");
    exp_at(t+1, K_CHG, 2'b11, "ena0_chg");
    exp_at(t+1, K_ACC1, 145, "ena0_acc1_frozen");
    exp_at(t+1, K_ACC0, 0, "ena0_acc0");
    exp_at(t+3, K_CHG, 0, "ena0_chg_end");
    exp_at(t+3, K_ACC1, 145, "ena0_acc1_hold");
    go(4);
    t = cyc; ena = 1'b1;
    exp_at(t+1, K_OE, 0, "ena1_oe_m1");
    exp_at(t+1, K_CHG, 0, "ena1_chg");
    exp_at(t+3, K_OE, 0, "ena1_oe_m1_hold");
    go(4);
    t = cyc; vip[1] = 1'b1;
    exp_at(t+3, K_OUT, 2'b10, "reen_out");
    exp_at(t+3, K_OE, 2'b10, "reen_oe");
    exp_at(t+3, K_CHG, 2'b10, "reen_chg");
    exp_at(t+4, K_ACC1, 146, "reen_acc1");
    go(5);

    // Independent channels, then asynchronous reset mid-cycle
    t = cyc; vip = 2'b01; vin = 2'b10;
    exp_at(t+3, K_OUT, 2'b01, "indep_out");
    exp_at(t+3, K_OE, 2'b11, "indep_oe");
    exp_at(t+3, K_CHG, 2'b11, "indep_chg");
    go(5);
    t = cyc;
    #2 rst = 1'b1;
    exp_at(t, K_OUT, 0, "arst_out");
    exp_at(t, K_OE, 0, "arst_oe");
    exp_at(t, K_CHG, 0, "arst_chg");
    exp_at(t, K_ACC0, 128, "arst_acc0");
    exp_at(t, K_ACC1, 128, "arst_acc1");
    #4 rst = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) go(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for edge %0d never checked", e.nm, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digi_ota_array.md
Name: digi_ota_array

Overview:
- Clocked, multi-channel successor to the gate-level digital OTA.
- Each channel takes a digitised differential pair (vip/vin), synchronises it, deglitches it, and drives a tri-state-style output (out + out_oe) through a per-channel state machine.
- Each channel also keeps a saturating up/down integrator that emulates transconductance charge onto a load.
- Sits between the analog-pin comparator front end and the project's digital pads and readout logic.

Parameters:
- CHANNELS, 2: number of independent OTA channels.
- SYNC_STAGES, 2: flip-flop synchroniser depth on vip/vin. Legal range 2..4.
- DEGLITCH_W, 4: width of the deglitch length control and of the per-channel persistence counter.
- ACC_W, 8: width of the per-channel integrator.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state.
- ena  input  1  global enable. Low forces all channels to HIZ.
- mode  input  1  0 = tri-state (common mode releases output); 1 = hold (output keeps last decision).
- deglitch_len  input  DEGLITCH_W  extra consecutive samples a new condition must persist.
- acc_clr  input  1  synchronous clear of all integrators to midscale.
- vip  input  CHANNELS  positive input per channel (asynchronous).
- vin  input  CHANNELS  negative input per channel (asynchronous).
- out  output  CHANNELS  drive value per channel.
- out_oe  output  CHANNELS  drive enable per channel (1 = driving).
- changed  output  CHANNELS  one-cycle pulse when a channel's committed condition changes.
- acc  output  CHANNELS*ACC_W  integrators, channel i at bits [i*ACC_W +: ACC_W].

Behaviour:
- **Reset (rst=1, async):**
  - Synchronisers 0; committed condition CM; counters 0; drive_seen 0.
  - out=0, out_oe=0, changed=0, every acc = 2^(ACC_W-1).
- **Classification** of the synchronised pair (s_vip, s_vin):
  - 10 → UP.
  - 01 → DN.
  - 00 or 11 → CM.
- **Per-channel FSM:** committed condition C ∈ {CM, UP, DN}; pending candidate P; counter cnt.
  - Sample == C: cnt cleared to 0, P discarded.
  - Sample != C and != P: P = sample, cnt = 0. If deglitch_len == 0, C = sample on this same edge.
  - Sample == P: cnt increments. When cnt+1 >= deglitch_len, C = P and cnt = 0.
  - Net effect: a new condition must be seen on deglitch_len+1 consecutive samples.
  - Comparison is >=, so lowering deglitch_len while a candidate is pending commits on the next matching sample.
- **Latency:** input change held stable → committed change visible on out/out_oe after SYNC_STAGES + deglitch_len + 1 rising edges. changed pulses in that same cycle.
- **Outputs are registered**, derived from the next C:
  - UP → out=1, oe=1.
  - DN → out=0, oe=1.
  - CM, mode=0 → oe=0, out=0.
  - CM, mode=1 → oe = drive_seen, out holds its last driven value.
- **drive_seen** sets on the first UP/DN commit. It clears on rst or on ena=0.
- **mode** may change at any time. The effect is visible on the next edge with no re-deglitching.
- **ena=0:**
  - Next edge: C=CM, cnt=0, drive_seen=0, out=0, oe=0.
  - changed pulses if C was UP/DN.
  - acc holds its value.
  - Synchronisers keep running.
- **Integrator**, per channel, one edge after commit, using registered C:
  - UP → +1.
  - DN → -1.
  - CM → hold.
  - Saturates at 2^ACC_W-1 and at 0; no wrap.
  - acc_clr has priority over any increment or decrement on the same edge.
- **Channel independence:** channels share no state except the global controls.
- **Simultaneous events:** rst overrides everything; ena=0 overrides pending commits; acc_clr is independent of ena.

Test Plan:
1. Reset, SYNC_STAGES=2, deglitch_len=0, mode=0: ch0 vip=1,vin=0 applied before edge 0 → out[0]=1, oe[0]=1, changed[0]=1 after edge 2 only. acc0 goes 128→129 at edge 3, then +1 per edge.
2. deglitch_len=3: 3-cycle vip=1 glitch → no commit, oe stays 0. A 4-cycle pulse → commit after edge 2+3+... i.e. 6 edges after the first sample. A DN glitch interleaved resets the count.
3. Mode contrast on UP then CM (vip=vin=1): mode=0 → oe=0 after latency. mode=1 → out=1, oe=1 retained. Switching to mode=0 while in CM → oe=0 on the next edge.
4. Saturation with ACC_W=8: hold UP for 200 cycles → acc0 stops at 255. Hold DN 300 cycles → stops at 0. acc_clr asserted during an UP increment → acc=128 that edge.
5. ena dropped mid-UP → next edge oe=0, out=0, changed=1, acc frozen. ena raised → re-commit after full latency; in mode=1, oe=0 until the first new decision.
6. rst asserted asynchronously between edges while channels are driving with CHANNELS=2 → outputs and acc reset immediately, not waiting for clk. Independent stimulus on ch0 (UP) and ch1 (DN) gives out=2'b01, oe=2'b11.
